// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
// Decimal stopwatch/timer for the board push-buttons and HEX displays.
// It counts up or down in BCD at TICK_HZ and offers start, stop, clear,
// preset load, a delayed start, and either wrap or saturate at full scale.
//
// Ports
//   CLOCK_50      system clock; all logic runs on its rising edge
//   RST_N         synchronous, active-low reset
//   start_n       push-button (active low): start counting
//   stop_n        push-button (active low): stop counting, value held
//   clear_n       push-button (active low): count to zero, go idle
//   delay_n       push-button (active low): delayed start
//   load_n        push-button (active low): load preset_bcd (idle/done only)
//   lap_n         push-button (active low): lap freeze toggle
//   mode_down     level: 0 counts up, 1 counts down
//   preset_bcd    preset value; digits above 9 load as 9
//   bcd           live count, digit 0 least significant
//   HEX           active-low segments, digit k at [7k+6:7k], order gfedcba
//   running       high while counting
//   delay_active  high during the delayed start
//   done          one-cycle pulse on wrap, saturation or countdown to zero
//
// Optional feature: define STOPWATCH_LAP_EN to enable the lap freeze on
// lap_n. Without it lap_n is unused and HEX always follows bcd.
module bcd_stopwatch #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 10,
    parameter int DIGITS      = 4,
    parameter int DELAY_TICKS = 30,
    parameter int WRAP        = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic                  start_n,
    input  logic                  stop_n,
    input  logic                  clear_n,
    input  logic                  delay_n,
    input  logic                  load_n,
    input  logic                  lap_n,
    input  logic                  mode_down,
    input  logic [4*DIGITS-1:0]   preset_bcd,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  running,
    output logic                  delay_active,
    output logic                  done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;

    localparam logic [PW-1:0]       PRESC_ZERO = PW'(32'd0);
    localparam logic [PW-1:0]       PRESC_ONE  = PW'(32'd1);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0]       DLY_ZERO   = DW'(32'd0);
    localparam logic [DW-1:0]       DLY_ONE    = DW'(32'd1);
    localparam logic [DW-1:0]       DLY_LAST   = DW'(DELAY_TICKS - 1);
    localparam logic [4*DIGITS-1:0] BCD_ZERO   = (4*DIGITS)'(32'd0);
    localparam logic [4*DIGITS-1:0] BCD_ONE    = (4*DIGITS)'(32'd1);
    localparam logic [4*DIGITS-1:0] BCD_NINES  = {DIGITS{4'h9}};

    // Event bit positions, also the resolution priority (lowest index wins)
    localparam int EV_CLR   = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_START = 2;
    localparam int EV_DLY   = 3;
    localparam int EV_LOAD  = 4;
    localparam int EV_LAP   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // BCD helpers: per-digit ripple carry/borrow, no binary divide.
    // ------------------------------------------------------------------
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        logic                carry;
        logic [3:0]          d;
        res   = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    res[4*k +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[4*k +: 4] = d + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[4*k +: 4] = d;
            end
        end
        return res;
    endfunction

    function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        logic                borrow;
        logic [3:0]          d;
        res    = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d = v[4*k +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    res[4*k +: 4] = 4'd9;
                    borrow        = 1'b1;
                end else begin
                    res[4*k +: 4] = d - 4'd1;
                    borrow        = 1'b0;
                end
            end else begin
                res[4*k +: 4] = d;
            end
        end
        return res;
    endfunction

    // Non-decimal preset digits are clamped to 9
    function automatic logic [4*DIGITS-1:0] bcd_clamp(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] res;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                res[4*k +: 4] = 4'd9;
            end else begin
                res[4*k +: 4] = v[4*k +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Buttons: 2-flop synchroniser, history flop, registered fall event.
    // ------------------------------------------------------------------
    logic [5:0] w_btn_n;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [5:0] r_sync3;
    logic [5:0] r_ev;
    logic [5:0] w_evt_top;

`ifdef STOPWATCH_LAP_EN
    assign w_btn_n = {lap_n, load_n, delay_n, start_n, stop_n, clear_n};
`else
    logic w_unused_lap;
    assign w_unused_lap = lap_n;
    assign w_btn_n      = {1'b1, load_n, delay_n, start_n, stop_n, clear_n};
`endif

    // Synchronise buttons and turn each high-to-low transition into one event
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_sync1 <= 6'h3F;
            r_sync2 <= 6'h3F;
            r_sync3 <= 6'h3F;
            r_ev    <= 6'h00;
        end else begin
            r_sync1 <= w_btn_n;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_ev    <= r_sync3 & ~r_sync2;
        end
    end

    // Keep only the highest-priority event of the cycle
    always_comb begin
        w_evt_top = 6'h00;
        if (r_ev[EV_CLR]) begin
            w_evt_top[EV_CLR] = 1'b1;
        end else if (r_ev[EV_STOP]) begin
            w_evt_top[EV_STOP] = 1'b1;
        end else if (r_ev[EV_START]) begin
            w_evt_top[EV_START] = 1'b1;
        end else if (r_ev[EV_DLY]) begin
            w_evt_top[EV_DLY] = 1'b1;
        end else if (r_ev[EV_LOAD]) begin
            w_evt_top[EV_LOAD] = 1'b1;
        end else if (r_ev[EV_LAP]) begin
            w_evt_top[EV_LAP] = 1'b1;
        end else begin
            w_evt_top = 6'h00;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, prescaler and counter
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [PW-1:0]       r_presc;
    logic [DW-1:0]       r_dcnt;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_running;
    logic                r_delay;
    logic                r_done;
    logic                w_idle_like;
    logic                w_start_ok;
    logic                w_tick;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    // A countdown from zero would finish immediately, so it is refused
    assign w_start_ok  = !(mode_down && (r_bcd == BCD_ZERO));
    assign w_tick      = (r_presc == PRESC_LAST);

    // State machine: events first, otherwise prescaler/tick processing
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_presc   <= PRESC_ZERO;
            r_dcnt    <= DLY_ZERO;
            r_bcd     <= BCD_ZERO;
            r_running <= 1'b0;
            r_delay   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_evt_top[EV_CLR]) begin
                r_bcd     <= BCD_ZERO;
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_delay   <= 1'b0;
            end else if (w_evt_top[EV_STOP] && !w_idle_like) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_delay   <= 1'b0;
            end else if (w_evt_top[EV_START] && w_idle_like && w_start_ok) begin
                r_state   <= ST_RUN;
                r_presc   <= PRESC_ZERO;
                r_running <= 1'b1;
                r_delay   <= 1'b0;
            end else if (w_evt_top[EV_DLY] && w_idle_like && w_start_ok) begin
                r_state   <= ST_DELAY;
                r_presc   <= PRESC_ZERO;
                r_dcnt    <= DLY_ZERO;
                r_running <= 1'b0;
                r_delay   <= 1'b1;
            end else if (w_evt_top[EV_LOAD] && w_idle_like) begin
                r_bcd     <= bcd_clamp(preset_bcd);
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_delay   <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_tick) begin
                            r_presc <= PRESC_ZERO;
                            if (mode_down) begin
                                // Zero is treated like one so a count that
                                // turned to down at zero also terminates
                                if ((r_bcd == BCD_ONE) || (r_bcd == BCD_ZERO)) begin
                                    r_bcd     <= BCD_ZERO;
                                    r_done    <= 1'b1;
                                    r_state   <= ST_DONE;
                                    r_running <= 1'b0;
                                end else begin
                                    r_bcd <= bcd_dec(r_bcd);
                                end
                            end else if (r_bcd == BCD_NINES) begin
                                r_done <= 1'b1;
                                if (WRAP != 0) begin
                                    r_bcd <= BCD_ZERO;
                                end else begin
                                    r_state   <= ST_DONE;
                                    r_running <= 1'b0;
                                end
                            end else begin
                                r_bcd <= bcd_inc(r_bcd);
                            end
                        end else begin
                            r_presc <= r_presc + PRESC_ONE;
                        end
                    end
                    ST_DELAY: begin
                        if (w_tick) begin
                            r_presc <= PRESC_ZERO;
                            if (r_dcnt == DLY_LAST) begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                                r_delay   <= 1'b0;
                            end else begin
                                r_dcnt <= r_dcnt + DLY_ONE;
                            end
                        end else begin
                            r_presc <= r_presc + PRESC_ONE;
                        end
                    end
                    default: begin
                        r_presc <= r_presc;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Lap freeze and display decode
    // ------------------------------------------------------------------
    logic                r_freeze;
    logic [4*DIGITS-1:0] r_lap_bcd;
    logic [4*DIGITS-1:0] w_disp;
    logic [7*DIGITS-1:0] r_hex;

    // Select the value to display: frozen lap value or live count
    always_comb begin
        if (r_freeze) begin
            w_disp = r_lap_bcd;
        end else begin
            w_disp = r_bcd;
        end
    end

    // Lap toggle (not affected by clear) and registered segment decode
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            r_freeze  <= 1'b0;
            r_lap_bcd <= BCD_ZERO;
            r_hex     <= {DIGITS{7'b1000000}};
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (w_evt_top[EV_LAP]) begin
                r_freeze  <= ~r_freeze;
                r_lap_bcd <= r_bcd;
            end else begin
                r_freeze  <= r_freeze;
                r_lap_bcd <= r_lap_bcd;
            end
`else
            r_freeze  <= 1'b0;
            r_lap_bcd <= BCD_ZERO;
`endif
            for (int k = 0; k < DIGITS; k++) begin
                r_hex[7*k +: 7] <= seg7(w_disp[4*k +: 4]);
            end
        end
    end

    assign bcd          = r_bcd;
    assign HEX          = r_hex;
    assign running      = r_running;
    assign delay_active = r_delay;
    assign done         = r_done;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: DIV=10, DIGITS=4, DELAY_TICKS=3.
// One wrapping instance and one saturating instance share the stimulus.
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        rst_n, start_n, stop_n, clear_n, delay_n, load_n, lap_n, mode_down;
    logic [15:0] preset;
    logic [15:0] bcd_w, bcd_s;
    logic [27:0] hex_w, hex_s;
    logic        run_w, run_s, dly_w, dly_s, done_w, done_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(4), .DELAY_TICKS(3), .WRAP(1)) u_dut (
        .CLOCK_50(clk), .RST_N(rst_n), .start_n(start_n), .stop_n(stop_n),
        .clear_n(clear_n), .delay_n(delay_n), .load_n(load_n), .lap_n(lap_n),
        .mode_down(mode_down), .preset_bcd(preset), .bcd(bcd_w), .HEX(hex_w),
        .running(run_w), .delay_active(dly_w), .done(done_w)
    );

    bcd_stopwatch #(.CLK_HZ(100), .TICK_HZ(10), .DIGITS(4), .DELAY_TICKS(3), .WRAP(0)) u_sat (
        .CLOCK_50(clk), .RST_N(rst_n), .start_n(start_n), .stop_n(stop_n),
        .clear_n(clear_n), .delay_n(delay_n), .load_n(load_n), .lap_n(lap_n),
        .mode_down(mode_down), .preset_bcd(preset), .bcd(bcd_s), .HEX(hex_s),
        .running(run_s), .delay_active(dly_s), .done(done_s)
    );

    typedef enum int {A_NONE, A_START, A_STOP, A_CLEAR, A_DELAY, A_LOAD, A_START_CLEAR, A_LAP} act_t;

    typedef struct {
        act_t        act;
        logic        mdown;
        logic [15:0] pre;
        int          wait_n;
        logic [15:0] e_bcd;
        logic        e_run;
        logic        e_dly;
        logic        e_done;
    } step_t;

    typedef struct {
        logic [15:0] bcd;
        logic        run;
        logic        dly;
        logic        done;
        logic [27:0] hex;
        logic        hex_en;
    } exp_t;

    step_t tbl[$];
    exp_t  exp_q[$];

    function automatic step_t mk(act_t a, logic md, logic [15:0] pre, int w,
                                 logic [15:0] eb, logic er, logic ed, logic edn);
        step_t s;
        s.act = a; s.mdown = md; s.pre = pre; s.wait_n = w;
        s.e_bcd = eb; s.e_run = er; s.e_dly = ed; s.e_done = edn;
        return s;
    endfunction

    // Reference 7-segment patterns, gfedcba active low
    function automatic logic [27:0] hex_of(logic [15:0] v);
        logic [27:0] h;
        logic [6:0]  s;
        for (int k = 0; k < 4; k++) begin
            case (v[4*k +: 4])
                4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
                4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
                4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
                4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
                4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
                default: s = 7'b1111111;
            endcase
            h[7*k +: 7] = s;
        end
        return h;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_main(input logic [15:0] b, input logic r, input logic d,
                               input logic dn, input logic [27:0] h, input logic he);
        exp_t e;
        e.bcd = b; e.run = r; e.dly = d; e.done = dn; e.hex = h; e.hex_en = he;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the wrapping instance
    task automatic check_main(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, ".bcd"}, {16'h0, bcd_w}, {16'h0, e.bcd});
            cmp({tag, ".running"}, {31'h0, run_w}, {31'h0, e.run});
            cmp({tag, ".delay_active"}, {31'h0, dly_w}, {31'h0, e.dly});
            cmp({tag, ".done"}, {31'h0, done_w}, {31'h0, e.done});
            if (e.hex_en) begin
                cmp({tag, ".HEX"}, {4'h0, hex_w}, {4'h0, e.hex});
            end
        end
    endtask

    // Hold one button (or pair) low for exactly one clock edge
    task automatic press(input act_t a);
        case (a)
            A_START:       start_n = 1'b0;
            A_STOP:        stop_n  = 1'b0;
            A_CLEAR:       clear_n = 1'b0;
            A_DELAY:       delay_n = 1'b0;
            A_LOAD:        load_n  = 1'b0;
            A_LAP:         lap_n   = 1'b0;
            A_START_CLEAR: begin start_n = 1'b0; clear_n = 1'b0; end
            default:       start_n = 1'b1;
        endcase
        @(negedge clk);
        start_n = 1'b1; stop_n = 1'b1; clear_n = 1'b1;
        delay_n = 1'b1; load_n = 1'b1; lap_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start_n = 1'b1; stop_n = 1'b1; clear_n = 1'b1;
        delay_n = 1'b1; load_n = 1'b1; lap_n = 1'b1; mode_down = 1'b0; preset = 16'h0000;

        //             act            md    preset   wait  bcd      run   dly   done
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0000,   1, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START,       1'b0, 16'h0000,   3, 16'h0000, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0000,   9, 16'h0000, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0000,   1, 16'h0001, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0000, 239, 16'h0024, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0000,   1, 16'h0025, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_STOP,        1'b0, 16'h0000,   3, 16'h0025, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0000,  20, 16'h0025, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_LOAD,        1'b0, 16'h9998,   3, 16'h9998, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START,       1'b0, 16'h9998,  13, 16'h9999, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h9998,   9, 16'h9999, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h9998,   1, 16'h0000, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h9998,   1, 16'h0000, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_CLEAR,       1'b0, 16'h9998,   3, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_LOAD,        1'b1, 16'h0003,   3, 16'h0003, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START,       1'b1, 16'h0003,  13, 16'h0002, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b1, 16'h0003,  10, 16'h0001, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b1, 16'h0003,  10, 16'h0000, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(A_NONE,        1'b1, 16'h0003,   1, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START,       1'b1, 16'h0003,  13, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_DELAY,       1'b1, 16'h0003,  13, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_DELAY,       1'b0, 16'h0003,   3, 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0003,  29, 16'h0000, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0003,   1, 16'h0000, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0003,   9, 16'h0000, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0003,   1, 16'h0001, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_STOP,        1'b0, 16'h0003,   3, 16'h0001, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_DELAY,       1'b0, 16'h0003,  13, 16'h0001, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(A_STOP,        1'b0, 16'h0003,   3, 16'h0001, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START,       1'b0, 16'h0003,   3, 16'h0001, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_LOAD,        1'b0, 16'h0500,   3, 16'h0001, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_STOP,        1'b0, 16'h0500,   3, 16'h0001, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START_CLEAR, 1'b0, 16'h0500,  13, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_LOAD,        1'b0, 16'h0041,   3, 16'h0041, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_START,       1'b0, 16'h0041,  13, 16'h0042, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(A_START_CLEAR, 1'b0, 16'h0041,   3, 16'h0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(A_NONE,        1'b0, 16'h0041,  10, 16'h0000, 1'b0, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            mode_down = tbl[i].mdown;
            preset    = tbl[i].pre;
            expect_main(tbl[i].e_bcd, tbl[i].e_run, tbl[i].e_dly, tbl[i].e_done, 28'h0, 1'b0);
            if (tbl[i].act != A_NONE) press(tbl[i].act);
            repeat (tbl[i].wait_n) @(negedge clk);
            check_main($sformatf("step%0d", i));
        end

        // HEX decode, lag of one cycle, and clamping of non-decimal preset digits
        preset = 16'hF3A7;
        press(A_LOAD);
        repeat (3) @(negedge clk);
        expect_main(16'h9397, 1'b0, 1'b0, 1'b0, hex_of(16'h0000), 1'b1);
        check_main("hex_lag");
        @(negedge clk);
        expect_main(16'h9397, 1'b0, 1'b0, 1'b0, hex_of(16'h9397), 1'b1);
        check_main("hex_9397");
        preset = 16'h0025;
        press(A_LOAD);
        repeat (4) @(negedge clk);
        expect_main(16'h0025, 1'b0, 1'b0, 1'b0, {7'b1000000, 7'b1000000, 7'b0100100, 7'b0010010}, 1'b1);
        check_main("hex_0025");

        // Saturating instance: 9998 -> 9999 -> done pulse, DONE, held
        preset = 16'h9998;
        press(A_LOAD);
        repeat (2) @(negedge clk);
        press(A_START);
        repeat (22) @(negedge clk);
        cmp("sat.bcd_before", {16'h0, bcd_s}, 32'h0000_9999);
        cmp("sat.done_before", {31'h0, done_s}, 32'd0);
        cmp("sat.run_before", {31'h0, run_s}, 32'd1);
        @(negedge clk);
        cmp("sat.bcd_at", {16'h0, bcd_s}, 32'h0000_9999);
        cmp("sat.done_at", {31'h0, done_s}, 32'd1);
        cmp("sat.run_at", {31'h0, run_s}, 32'd0);
        expect_main(16'h0000, 1'b1, 1'b0, 1'b1, 28'h0, 1'b0);
        check_main("wrap_same_edge");
        repeat (10) @(negedge clk);
        cmp("sat.bcd_held", {16'h0, bcd_s}, 32'h0000_9999);
        cmp("sat.done_after", {31'h0, done_s}, 32'd0);

        // Reset mid-count, then a press during reset must be ignored
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        expect_main(16'h0000, 1'b0, 1'b0, 1'b0, hex_of(16'h0000), 1'b1);
        check_main("reset_mid");
        cmp("reset.sat_bcd", {16'h0, bcd_s}, 32'd0);
        press(A_START);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        expect_main(16'h0000, 1'b0, 1'b0, 1'b0, hex_of(16'h0000), 1'b1);
        check_main("press_in_reset");

`ifdef STOPWATCH_LAP_EN
        // Lap freeze at 0017, five ticks later HEX still 0017 while bcd=0022
        preset = 16'h0017;
        press(A_LOAD);
        repeat (3) @(negedge clk);
        press(A_START);
        repeat (3) @(negedge clk);
        press(A_LAP);
        repeat (50) @(negedge clk);
        expect_main(16'h0022, 1'b1, 1'b0, 1'b0, hex_of(16'h0017), 1'b1);
        check_main("lap_frozen");
        press(A_LAP);
        repeat (3) @(negedge clk);
        expect_main(16'h0022, 1'b1, 1'b0, 1'b0, hex_of(16'h0017), 1'b1);
        check_main("lap_release_lag");
        @(negedge clk);
        expect_main(16'h0022, 1'b1, 1'b0, 1'b0, hex_of(16'h0022), 1'b1);
        check_main("lap_released");
        press(A_STOP);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
